// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment display driver:
// active-low segment font, conversion FSM states and the BCD adjust step.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  function automatic logic [6:0] seg7_font(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  function automatic logic [3:0] bcd_adj(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: one 8-bit binary value to 3-digit BCD,
// one bit per clock after start; done flags the cycle of the final shift.
module bin2bcd_seq #(
  parameter logic [3:0] CONV_BITS = 4'd8
) (
  input  logic        clk,
  input  logic        sys_reset_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);
  import seg7_pkg::*;

  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_active;
  logic [11:0] w_adj;

  assign w_adj = {bcd_adj(r_bcd[11:8]), bcd_adj(r_bcd[7:4]), bcd_adj(r_bcd[3:0])};

  // Load on start, then adjust-and-shift once per cycle for CONV_BITS cycles
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_bin    <= 8'd0;
      r_bcd    <= 12'd0;
      r_cnt    <= 4'd0;
      r_active <= 1'b0;
    end else if (start) begin
      r_bin    <= bin;
      r_bcd    <= 12'd0;
      r_cnt    <= 4'd0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd <= {w_adj[10:0], r_bin[7]};
      r_bin <= {r_bin[6:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == (CONV_BITS - 4'd1)) begin
        r_active <= 1'b0;
      end
    end
  end

  assign bcd  = r_bcd;
  assign done = r_active && (r_cnt == (CONV_BITS - 4'd1));

endmodule

// File: rtl/seg7_scan_driver.sv
// Converts two binary fields to BCD, holds them in digit registers updated
// atomically, and scans them onto a 4-digit common-anode display.
module seg7_scan_driver #(
  parameter logic [15:0] SCAN_DIV  = 16'd49_999,
  parameter logic [3:0]  CONV_BITS = 4'd8
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       EN,
  input  logic [7:0] data_hi,
  input  logic [7:0] data_lo,
  input  logic [3:0] point,
  output logic [3:0] sel,
  output logic [7:0] seg,
  output logic       busy
);
  import seg7_pkg::*;

  conv_state_e     r_state;
  conv_state_e     w_next;
  logic [7:0]      r_shadow_hi;
  logic [7:0]      r_shadow_lo;
  logic [3:0][3:0] r_digits;
  logic            r_busy;
  logic [15:0]     r_presc;
  logic [1:0]      r_idx;
  logic [3:0]      r_sel;
  logic [7:0]      r_seg;
  logic            w_start;
  logic [11:0]     w_bcd_hi;
  logic [11:0]     w_bcd_lo;
  logic            w_done_hi;
  logic            w_done_lo;
  logic [7:0]      w_pair_hi;
  logic [7:0]      w_pair_lo;

  assign w_start = (r_state == ST_LOAD);

  bin2bcd_seq #(.CONV_BITS(CONV_BITS)) u_conv_hi (
    .clk(clk), .sys_reset_n(sys_reset_n), .start(w_start),
    .bin(data_hi), .bcd(w_bcd_hi), .done(w_done_hi)
  );

  bin2bcd_seq #(.CONV_BITS(CONV_BITS)) u_conv_lo (
    .clk(clk), .sys_reset_n(sys_reset_n), .start(w_start),
    .bin(data_lo), .bcd(w_bcd_lo), .done(w_done_lo)
  );

  // Values of 100 and above cannot fit two digits, so they saturate to 99
  assign w_pair_hi = (w_bcd_hi[11:8] != 4'd0) ? 8'h99 : w_bcd_hi[7:0];
  assign w_pair_lo = (w_bcd_lo[11:8] != 4'd0) ? 8'h99 : w_bcd_lo[7:0];

  // Conversion FSM state register
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Conversion FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if ((data_hi != r_shadow_hi) || (data_lo != r_shadow_lo)) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_done_hi && w_done_lo) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_SHIFT;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Shadow copies, busy flag and atomic digit update
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_shadow_hi <= 8'd0;
      r_shadow_lo <= 8'd0;
      r_digits    <= 16'd0;
      r_busy      <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_shadow_hi <= data_hi;
      r_shadow_lo <= data_lo;
      r_busy      <= 1'b1;
    end else if (r_state == ST_DONE) begin
      r_digits <= {w_pair_hi, w_pair_lo};
      r_busy   <= 1'b0;
    end
  end

  // Digit-slot prescaler and scan index, frozen while disabled
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_presc <= 16'd0;
      r_idx   <= 2'd0;
    end else if (EN) begin
      if (r_presc == SCAN_DIV) begin
        r_presc <= 16'd0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  // Registered digit select and segment drive; point bypasses conversion
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_sel <= 4'hF;
      r_seg <= 8'hFF;
    end else if (EN) begin
      r_sel <= ~(4'b0001 << r_idx);
      r_seg <= {~point[r_idx], seg7_font(r_digits[r_idx])};
    end else begin
      r_sel <= 4'hF;
      r_seg <= 8'hFF;
    end
  end

  assign sel  = r_sel;
  assign seg  = r_seg;
  assign busy = r_busy;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps plus random values,
// checked against an arithmetic model of the displayed digits.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       sys_reset_n;
  logic       EN;
  logic [7:0] data_hi;
  logic [7:0] data_lo;
  logic [3:0] point;
  logic [3:0] sel;
  logic [7:0] seg;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_hi = 0;
  int         m_lo = 0;
  logic [3:0] m_pt = 4'b0000;

  logic [6:0] font_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(16'd3), .CONV_BITS(4'd8)) dut (
    .clk(clk), .sys_reset_n(sys_reset_n), .EN(EN),
    .data_hi(data_hi), .data_lo(data_lo), .point(point),
    .sel(sel), .seg(seg), .busy(busy)
  );

  function automatic int clampv(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // Expected segment byte for display position i (3 = leftmost)
  function automatic logic [7:0] exp_seg(input int i);
    int hv, lv, d;
    hv = clampv(m_hi);
    lv = clampv(m_lo);
    case (i)
      3:       d = hv / 10;
      2:       d = hv % 10;
      1:       d = lv / 10;
      default: d = lv % 10;
    endcase
    return {~m_pt[i], font_tbl[d]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input int hi, input int lo, input logic [3:0] pt);
    @(negedge clk);
    data_hi = hi[7:0];
    data_lo = lo[7:0];
    point   = pt;
    m_hi    = hi;
    m_lo    = lo;
    m_pt    = pt;
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_rise"}, n, 2);
  endtask

  task automatic wait_fall(input string tag, input int exp_len);
    int h = 0;
    while (busy === 1'b1 && h < 30) begin
      @(negedge clk);
      h++;
    end
    check({tag, "_busy_len"}, h, exp_len);
  endtask

  // Watch 16 cycles: valid one-hot select, right glyph, rotation order, 4-cycle dwell
  task automatic check_scan(input string tag);
    int cnt [4];
    int prev = -1;
    int idx;
    logic [3:0] pat;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = -1;
      for (int j = 0; j < 4; j++) begin
        pat = ~(4'b0001 << j);
        if (sel === pat) idx = j;
      end
      check({tag, "_sel_valid"}, (idx >= 0), 1);
      if (idx >= 0) begin
        check({tag, "_seg"}, seg, exp_seg(idx));
        cnt[idx]++;
        if (prev >= 0 && idx != prev) check({tag, "_order"}, idx, (prev + 1) % 4);
        prev = idx;
      end
    end
    for (int j = 0; j < 4; j++) check({tag, "_dwell"}, cnt[j], 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int k;
    int hi, lo;
    int busy_cnt;

    // Step 1: reset state, then release with zero inputs
    sys_reset_n = 1'b0;
    EN      = 1'b1;
    data_hi = 8'd0;
    data_lo = 8'd0;
    point   = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 4'hF);
    check("rst_seg", seg, 8'hFF);
    check("rst_busy", busy, 1'b0);
    sys_reset_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    check("t1_no_conv", busy_cnt, 0);
    check_scan("t1");

    // Step 2: 12 / 59 with the point after digit 2
    apply(12, 59, 4'b0100);
    wait_rise("t2");
    wait_fall("t2", 9);
    check_scan("t2");

    // Step 3: low field out of range saturates to 99
    apply(12, 150, 4'b0100);
    wait_rise("t3");
    wait_fall("t3", 9);
    check_scan("t3");

    // Step 4: input change during the third shift cycle
    apply(12, 59, 4'b0100);
    wait_rise("t4a");
    repeat (2) @(negedge clk);
    data_lo = 8'd0;
    m_lo    = 0;
    wait_fall("t4a", 7);
    wait_rise("t4b");
    wait_fall("t4b", 9);
    check_scan("t4");

    // Step 5: disable during slot 2, change data, re-enable
    k = 0;
    while (sel !== 4'hD && k < 40) begin @(negedge clk); k++; end
    while (sel !== 4'hB && k < 40) begin @(negedge clk); k++; end
    check("t5_slot2_found", sel, 4'hB);
    EN = 1'b0;
    @(negedge clk);
    check("t5_off_sel", sel, 4'hF);
    check("t5_off_seg", seg, 8'hFF);
    apply(7, m_lo, m_pt);
    wait_rise("t5");
    wait_fall("t5", 9);
    check("t5_still_off_sel", sel, 4'hF);
    check("t5_still_off_seg", seg, 8'hFF);
    EN = 1'b1;
    @(negedge clk);
    check("t5_resume_sel", sel, 4'hB);
    check("t5_resume_seg", seg, exp_seg(2));
    check_scan("t5");

    // Step 6: reset in the middle of a conversion
    hi = $urandom_range(10, 99);
    lo = $urandom_range(0, 255);
    apply(hi, lo, 4'($urandom_range(0, 15)));
    wait_rise("t6a");
    repeat (2) @(negedge clk);
    #2;
    sys_reset_n = 1'b0;
    #1;
    check("t6_rst_sel", sel, 4'hF);
    check("t6_rst_seg", seg, 8'hFF);
    check("t6_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    sys_reset_n = 1'b1;
    wait_rise("t6b");
    wait_fall("t6b", 9);
    check_scan("t6");

    // Random values across the full 8-bit range
    for (int r = 0; r < 6; r++) begin
      hi = $urandom_range(0, 255);
      lo = $urandom_range(0, 255);
      if (hi == m_hi && lo == m_lo) lo = (lo + 1) % 256;
      apply(hi, lo, 4'($urandom_range(0, 15)));
      wait_rise("rnd");
      wait_fall("rnd", 9);
      check_scan("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
